// File: rtl/ucpu_defs.sv
// Shared definitions for the ASCII hex parser: word width, character codes,
// parser state encoding and error codes.
package ucpu_defs;

    localparam int DATA_SIZE = 32;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    localparam logic [1:0] ERR_BAD_CHAR = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII classifier: maps hex digits (either case) to a nibble and
// flags line terminators and spaces. Inverse of the nibble-to-ASCII map.
module hex_char_decode
    import ucpu_defs::*;
(
    input  logic [7:0] char_i,
    output logic [3:0] nibble_o,
    output logic       is_hex_o,
    output logic       is_term_o,
    output logic       is_space_o
);

    always_comb begin
        nibble_o   = 4'h0;
        is_hex_o   = 1'b0;
        is_term_o  = (char_i == CHAR_LF) || (char_i == CHAR_CR);
        is_space_o = (char_i == CHAR_SPACE);
        if (char_i inside {[8'h30:8'h39]}) begin
            nibble_o = char_i[3:0];
            is_hex_o = 1'b1;
        end else if (char_i inside {[8'h41:8'h46], [8'h61:8'h66]}) begin
            // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
            nibble_o = char_i[3:0] + 4'd9;
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/ascii_hex_to_binary.sv
// Accumulates ASCII hex digits MSB-first into a DATA_SIZE-bit word and offers it
// on a valid/ready port when a line terminator arrives; rejected lines are flushed.
module ascii_hex_to_binary
    import ucpu_defs::*;
#(
    parameter int DATA_SIZE = ucpu_defs::DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           char_in,
    input  logic                 char_valid,
    output logic                 char_ready,
    output logic [DATA_SIZE-1:0] value_out,
    output logic                 value_valid,
    input  logic                 value_ready,
    output logic [3:0]           digit_count,
    output logic                 error,
    output logic [1:0]           error_code
);

    localparam int         MAX_DIGITS = DATA_SIZE / 4;
    localparam logic [3:0] MAX_CNT    = 4'(MAX_DIGITS);

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d;
    logic [DATA_SIZE-1:0] value_q, value_d;
    logic                 valid_q, valid_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;

    logic [3:0] nibble;
    logic       is_hex;
    logic       is_term;
    logic       is_space;
    logic       accept;

    hex_char_decode u_decode (
        .char_i     (char_in),
        .nibble_o   (nibble),
        .is_hex_o   (is_hex),
        .is_term_o  (is_term),
        .is_space_o (is_space)
    );

    assign char_ready  = (state_q != S_HOLD);
    assign accept      = char_valid && char_ready;
    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign digit_count = cnt_q;
    assign error       = err_q;
    assign error_code  = code_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_hex) begin
                        acc_d   = {{(DATA_SIZE-4){1'b0}}, nibble};
                        cnt_d   = 4'd1;
                        state_d = S_ACCUM;
                    end else if (!(is_term || is_space)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_CHAR;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (is_hex && (cnt_q != MAX_CNT)) begin
                        acc_d = {acc_q[DATA_SIZE-5:0], nibble};
                        cnt_d = cnt_q + 4'd1;
                    end else if (is_term) begin
                        value_d = acc_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        // Too many digits, a space, or a non-hex char rejects the line.
                        err_d   = 1'b1;
                        code_d  = is_hex ? ERR_OVERFLOW : ERR_BAD_CHAR;
                        acc_d   = '0;
                        cnt_d   = 4'd0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_HOLD: begin
                if (valid_q && value_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (accept && is_term) begin
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascii_hex_to_binary.sv
// Directed bench for ascii_hex_to_binary: feeds character lines and compares taken
// words, digit counts and error pulses against hand-computed values.
module tb_ascii_hex_to_binary;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [31:0] value_out;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  digit_count;
    logic        error;
    logic [1:0]  error_code;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [31:0] word_q[$];
    logic [3:0]  cnt_q[$];
    logic [1:0]  err_q[$];

    ascii_hex_to_binary #(.DATA_SIZE(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .value_out   (value_out),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .digit_count (digit_count),
        .error       (error),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so the falling edge sees
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (reset_n && value_valid && value_ready) begin
            word_q.push_back(value_out);
            cnt_q.push_back(digit_count);
        end
        if (reset_n && error) err_q.push_back(error_code);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        char_in    = c;
        char_valid = 1'b1;
        @(negedge clk);
        while (!char_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check_eq("char_accept_timeout", 64'(char_ready), 64'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        word_q.delete();
        cnt_q.delete();
        err_q.delete();
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic [3:0] c);
        check_eq({tag, "_nwords"}, 64'(word_q.size()), 64'd1);
        if (word_q.size() > 0) begin
            check_eq({tag, "_value"}, 64'(word_q[0]), 64'(w));
            check_eq({tag, "_count"}, 64'(cnt_q[0]), 64'(c));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        char_in     = 8'h00;
        char_valid  = 1'b0;
        value_ready = 1'b1;
        #3;
        check_eq("rst_value_out", 64'(value_out), 64'h0);
        check_eq("rst_value_valid", 64'(value_valid), 64'd0);
        check_eq("rst_digit_count", 64'(digit_count), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_error_code", 64'(error_code), 64'd0);
        check_eq("rst_char_ready", 64'(char_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        clear_logs();
        send_str("1A2b\n");
        settle();
        expect_word("t1", 32'h00001A2B, 4'd4);
        check_eq("t1_nerr", 64'(err_q.size()), 64'd0);

        clear_logs();
        send_str("DEADBEEF\r\n");
        settle();
        expect_word("t2", 32'hDEADBEEF, 4'd8);
        check_eq("t2_nerr", 64'(err_q.size()), 64'd0);

        clear_logs();
        send_str("123456789\n");
        settle();
        check_eq("t3_nwords", 64'(word_q.size()), 64'd0);
        check_eq("t3_nerr", 64'(err_q.size()), 64'd1);
        if (err_q.size() > 0) check_eq("t3_err_code", 64'(err_q[0]), 64'h2);
        check_eq("t3_code_held", 64'(error_code), 64'h2);
        clear_logs();
        send_str("7\n");
        settle();
        expect_word("t3b", 32'h00000007, 4'd1);

        clear_logs();
        send_str("12G4\n");
        settle();
        check_eq("t4_nwords", 64'(word_q.size()), 64'd0);
        check_eq("t4_nerr", 64'(err_q.size()), 64'd1);
        if (err_q.size() > 0) check_eq("t4_err_code", 64'(err_q[0]), 64'h1);
        clear_logs();
        send_str("\n\r\n");
        settle();
        check_eq("t4b_nwords", 64'(word_q.size()), 64'd0);
        check_eq("t4b_nerr", 64'(err_q.size()), 64'd0);
        check_eq("t4b_code_held", 64'(error_code), 64'h1);

        clear_logs();
        value_ready = 1'b0;
        send_str("5\n");
        fork
            send_str("6\n");
            begin
                repeat (10) @(negedge clk);
                check_eq("t5_char_ready_held", 64'(char_ready), 64'd0);
                check_eq("t5_value_held", 64'(value_out), 64'h5);
                check_eq("t5_valid_held", 64'(value_valid), 64'd1);
                check_eq("t5_count_held", 64'(digit_count), 64'd1);
                @(posedge clk);
                #1;
                value_ready = 1'b1;
            end
        join
        settle();
        check_eq("t5_nwords", 64'(word_q.size()), 64'd2);
        if (word_q.size() > 1) begin
            check_eq("t5_first", 64'(word_q[0]), 64'h5);
            check_eq("t5_second", 64'(word_q[1]), 64'h6);
        end
        check_eq("t5_nerr", 64'(err_q.size()), 64'd0);

        clear_logs();
        send_str("AB");
        check_eq("t6_partial_count", 64'(digit_count), 64'd2);
        reset_n = 1'b0;
        #2;
        check_eq("t6_rst_value_out", 64'(value_out), 64'h0);
        check_eq("t6_rst_count", 64'(digit_count), 64'd0);
        check_eq("t6_rst_valid", 64'(value_valid), 64'd0);
        check_eq("t6_rst_error", 64'(error), 64'd0);
        check_eq("t6_rst_char_ready", 64'(char_ready), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_str("C\n");
        settle();
        expect_word("t6", 32'h0000000C, 4'd1);
        check_eq("t6_nerr", 64'(err_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
